// File: rtl/fp32_div.sv
// IEEE-754 binary32 divider: combinational restoring-division core with registered outputs.
// Rounds toward zero and flushes tiny results to zero. Accepts a new operand pair every clock.
module fp32_div (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [1:0] {
    RES_NAN,
    RES_INF,
    RES_ZERO,
    RES_CALC
  } res_kind_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Number of leading zeros in a 24-bit mantissa (only meaningful for nonzero input).
  function automatic logic [4:0] lzc24(input logic [23:0] m);
    logic [4:0] n;
    n = 5'd0;
    for (int unsigned i = 0; i < 24; i++) begin
      if (m[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

  logic        sa, sb, sq;
  logic [7:0]  expa, expb;
  logic [22:0] fraca, fracb;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  res_kind_t   kind;

  logic [4:0]        lza, lzb;
  logic [23:0]       ma, mb;
  logic signed [9:0] ea, eb;

  logic [24:0]       rem;
  logic [24:0]       q;
  logic [22:0]       frac;
  logic              adj;
  logic signed [9:0] e_biased;

  logic [31:0] result_d;
  logic        overflow_d, underflow_d;

  assign {sa, expa, fraca} = A;
  assign {sb, expb, fracb} = B;
  assign sq = sa ^ sb;

  assign nan_a  = (expa == 8'hFF) && (fraca != '0);
  assign nan_b  = (expb == 8'hFF) && (fracb != '0);
  assign inf_a  = (expa == 8'hFF) && (fraca == '0);
  assign inf_b  = (expb == 8'hFF) && (fracb == '0);
  assign zero_a = (expa == 8'h00) && (fraca == '0);
  assign zero_b = (expb == 8'h00) && (fracb == '0);

  always_comb begin
    kind = RES_CALC;
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) kind = RES_NAN;
    else if (inf_a)                                              kind = RES_INF;
    else if (zero_b)                                             kind = RES_INF;
    else if (zero_a || inf_b)                                    kind = RES_ZERO;
  end

  // Subnormals are normalized up front so the divider always sees mantissas in [1,2).
  always_comb begin
    lza = '0;
    lzb = '0;
    if (expa == 8'h00) begin
      lza = lzc24({1'b0, fraca});
      ma  = {1'b0, fraca} << lza;
      ea  = -10'sd126 - $signed({5'd0, lza});
    end else begin
      ma  = {1'b1, fraca};
      ea  = $signed({2'b00, expa}) - 10'sd127;
    end
    if (expb == 8'h00) begin
      lzb = lzc24({1'b0, fracb});
      mb  = {1'b0, fracb} << lzb;
      eb  = -10'sd126 - $signed({5'd0, lzb});
    end else begin
      mb  = {1'b1, fracb};
      eb  = $signed({2'b00, expb}) - 10'sd127;
    end
  end

  // Restoring division: q[24] has weight 2^0, q[0] weight 2^-24. Since ma/mb is in (0.5,2)
  // these 25 bits always hold a normalized 1.23 mantissa after at most one shift.
  always_comb begin
    rem = {1'b0, ma};
    q   = '0;
    for (int unsigned i = 0; i < 25; i++) begin
      if (rem >= {1'b0, mb}) begin
        rem        = rem - {1'b0, mb};
        q[24 - i]  = 1'b1;
      end
      rem = {rem[23:0], 1'b0};
    end
  end

  always_comb begin
    if (q[24]) begin
      frac = q[23:1];
      adj  = 1'b0;
    end else begin
      frac = q[22:0];
      adj  = 1'b1;
    end
    e_biased = ea - eb + 10'sd127 - $signed({9'd0, adj});
  end

  always_comb begin
    result_d    = '0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    unique case (kind)
      RES_NAN:  result_d = QNAN;
      RES_INF:  result_d = {sq, 8'hFF, 23'd0};
      RES_ZERO: result_d = {sq, 31'd0};
      RES_CALC: begin
        if (e_biased >= 10'sd255) begin
          result_d   = {sq, 8'hFF, 23'd0};
          overflow_d = 1'b1;
        end else if (e_biased <= 10'sd0) begin
          result_d    = {sq, 31'd0};
          underflow_d = 1'b1;
        end else begin
          result_d = {sq, e_biased[7:0], frac};
        end
      end
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      result    <= result_d;
      overflow  <= overflow_d;
      underflow <= underflow_d;
    end
  end

endmodule

// File: tb/tb_fp32_div.sv
// Self-checking bench for fp32_div: directed vectors with fixed answers, then random
// operands checked against an exact big-integer reference of truncated division.
module tb_fp32_div;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B;
  logic [31:0] result;
  logic        overflow, underflow;

  int checks   = 0;
  int failures = 0;

  logic [33:0] prev_exp;

  fp32_div dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Value of a finite operand is m * 2^e with an integer mantissa; the quotient is formed
  // exactly as a wide integer, then truncated to 24 significant bits.
  function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [7:0]  xa, xb;
    logic [22:0] fa, fb;
    logic        na, nb, ia, ib, za, zb;
    logic [95:0] num, den, q, sh;
    int          ea, eb, p, e;
    s  = a[31] ^ b[31];
    xa = a[30:23]; fa = a[22:0];
    xb = b[30:23]; fb = b[22:0];
    na = (xa == 8'hFF) && (fa != 0);
    nb = (xb == 8'hFF) && (fb != 0);
    ia = (xa == 8'hFF) && (fa == 0);
    ib = (xb == 8'hFF) && (fb == 0);
    za = (xa == 0) && (fa == 0);
    zb = (xb == 0) && (fb == 0);
    if (na || nb || (za && zb) || (ia && ib)) return {2'b00, 32'h7FC00000};
    if (ia || zb) return {2'b00, s, 8'hFF, 23'd0};
    if (za || ib) return {2'b00, s, 31'd0};
    if (xa == 0) begin num = {73'd0, fa}; ea = -149; end
    else begin num = {72'd0, 1'b1, fa}; ea = int'(xa) - 150; end
    if (xb == 0) begin den = {73'd0, fb}; eb = -149; end
    else begin den = {72'd0, 1'b1, fb}; eb = int'(xb) - 150; end
    num = num << 48;
    q   = num / den;
    p   = 0;
    for (int i = 0; i < 96; i++) if (q[i]) p = i;
    e = p + ea - eb - 48 + 127;
    if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
    if (e <= 0)   return {2'b01, s, 31'd0};
    sh = q >> (p - 23);
    return {2'b00, s, e[7:0], sh[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    int unsigned sel;
    r   = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0: r[30:0] = '0;
      1: r[30:0] = {8'hFF, 23'd0};
      2: r[30:0] = {8'hFF, r[22:1], 1'b1};
      3: r[30:0] = {8'h00, r[22:1], 1'b1};
      4: r[30:23] = 8'($urandom_range(1, 10));
      5: r[30:23] = 8'($urandom_range(245, 254));
      default: r[30:23] = 8'($urandom_range(1, 254));
    endcase
    return r;
  endfunction

  // Inputs change at the falling edge; outputs must still show the previous result until
  // the next rising edge, then show the new one.
  task automatic run_vec(input logic [31:0] a, input logic [31:0] b, input logic [33:0] exp,
                         input string tag);
    @(negedge clk);
    A = a;
    B = b;
    #1;
    check_eq({tag, "_hold_res"}, result, prev_exp[31:0]);
    check_eq({tag, "_hold_flags"}, {30'd0, overflow, underflow}, {30'd0, prev_exp[33:32]});
    @(posedge clk);
    #1;
    check_eq({tag, "_res"}, result, exp[31:0]);
    check_eq({tag, "_flags"}, {30'd0, overflow, underflow}, {30'd0, exp[33:32]});
    prev_exp = exp;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t dir[14] = '{
    '{32'h3FC00000, 32'h40300000, 32'h3F0BA2E8, 1'b0, 1'b0},
    '{32'hC0600000, 32'hBFA00000, 32'h40333333, 1'b0, 1'b0},
    '{32'h00400000, 32'h00400000, 32'h3F800000, 1'b0, 1'b0},
    '{32'h00400000, 32'h00200000, 32'h40000000, 1'b0, 1'b0},
    '{32'h00C00000, 32'h00A00000, 32'h3F999999, 1'b0, 1'b0},
    '{32'hC4FC74CD, 32'h00000000, 32'hFF800000, 1'b0, 1'b0},
    '{32'h00000000, 32'hC4FC74CD, 32'h80000000, 1'b0, 1'b0},
    '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0},
    '{32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0},
    '{32'h4128A3D7, 32'hFF800000, 32'h80000000, 1'b0, 1'b0},
    '{32'h4128A3D7, 32'hFF800001, 32'h7FC00000, 1'b0, 1'b0},
    '{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b1, 1'b0},
    '{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b1},
    '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b0}
  };

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    logic [33:0] last;
    rst = 1'b1;
    A   = 32'h3FC00000;
    B   = 32'h40300000;
    #12;
    check_eq("reset_res", result, 32'h0);
    check_eq("reset_flags", {30'd0, overflow, underflow}, 32'h0);
    @(posedge clk);
    #1;
    check_eq("reset_held_res", result, 32'h0);

    // First edge after deassertion loads the quotient of the inputs already present.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("release_res", result, 32'h3F0BA2E8);
    prev_exp = {2'b00, 32'h3F0BA2E8};

    for (int i = 0; i < 14; i++)
      run_vec(dir[i].a, dir[i].b, {dir[i].ovf, dir[i].unf, dir[i].res}, $sformatf("dir%0d", i));

    run_vec(32'h3FC00000, 32'h40300000, {2'b00, 32'h3F0BA2E8}, "pre_rst");
    last = prev_exp;

    // Asynchronous reset between edges must clear outputs without waiting for a clock.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("async_rst_res", result, 32'h0);
    check_eq("async_rst_flags", {30'd0, overflow, underflow}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rerelease_res", result, last[31:0]);
    prev_exp = last;

    for (int i = 0; i < 400; i++) begin
      a = rand_op();
      b = rand_op();
      run_vec(a, b, ref_div(a, b), $sformatf("rnd%0d_%08h_%08h", i, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
